// File: rtl/player_stats.sv
// ============================================================================
//  Module   : player_stats
//  Function : Per-player life/money bookkeeping with NUM_SRC weighted damage
//             sources, post-hit invulnerability window and a life FSM.
//  Options  : PLAYER_STATS_REGEN_EN enables slow life regeneration in ALIVE.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module player_stats #(
    parameter int NUM_SRC       = 2,
    parameter int LIFE_MAX      = 10,
    parameter int MONEY_W       = 7,
    parameter int MONEY_MAX     = 99,
    parameter int MONEY_INIT    = 20,
    parameter int TICKET_COST   = 10,
    parameter int DEATH_PENALTY = 5,
    parameter int INVULN_CYC    = 8,
    parameter int REGEN_PERIOD  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     state_i,
    input  logic [NUM_SRC-1:0]             damage_i,
    input  logic [NUM_SRC-1:0]             hit_i,
    input  logic                           ticket_i,
    output logic [LIFE_MAX-1:0]            life_o,
    output logic [$clog2(LIFE_MAX+1)-1:0]  dmg_o,
    output logic [MONEY_W-1:0]             money_o,
    output logic [1:0]                     phase_o,
    output logic                           fail_o,
    output logic                           dead_pulse_o
);

    localparam int DW   = $clog2(LIFE_MAX + 1);
    localparam int SMAX = NUM_SRC * (NUM_SRC + 1) / 2;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int AW   = ((DW > SW) ? DW : SW) + 1;
    localparam int HW   = $clog2(NUM_SRC + 1);
    localparam int MW   = MONEY_W + HW;
    localparam int TW   = (INVULN_CYC > 1) ? $clog2(INVULN_CYC) : 1;

    localparam logic [TW-1:0]       GUARD_LOAD = TW'((INVULN_CYC > 0) ? INVULN_CYC - 1 : 0);
    localparam logic [LIFE_MAX-1:0] FULL_BAR   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIVE = 2'd1,
        GUARD = 2'd2,
        DEAD  = 2'd3
    } phase_t;

    if (LIFE_MAX < 1 || REGEN_PERIOD < 1 || NUM_SRC < 1) begin : g_param_check
        $error("player_stats: LIFE_MAX, REGEN_PERIOD and NUM_SRC must be >= 1");
    end

    phase_t              phase_q, phase_d;
    logic [DW-1:0]       dmg_q, dmg_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [MONEY_W-1:0]  money_q, money_d;
    logic [LIFE_MAX-1:0] life_q, life_d;
    logic                fail_q;
    logic                dead_pulse_q;

    logic                play;
    logic                dead_entry;
    logic [AW-1:0]       dmg_sum;
    logic [AW-1:0]       dmg_acc;
    logic [HW-1:0]       hit_cnt;
    logic [MW-1:0]       money_acc;

`ifdef PLAYER_STATS_REGEN_EN
    localparam int RW = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
    logic [RW-1:0] regen_q, regen_d;
`endif

    assign play = (state_i >= 4'd1) && (state_i <= 4'd4);

    always_comb begin
        dmg_sum = '0;
        hit_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (damage_i[i]) dmg_sum = dmg_sum + AW'(i + 1);
            if (hit_i[i])    hit_cnt = hit_cnt + HW'(1);
        end
        dmg_acc = AW'(dmg_q) + dmg_sum;

        phase_d    = phase_q;
        dmg_d      = dmg_q;
        timer_d    = timer_q;
        dead_entry = 1'b0;
`ifdef PLAYER_STATS_REGEN_EN
        regen_d    = '0;
`endif

        if (!play) begin
            phase_d = IDLE;
            dmg_d   = '0;
            timer_d = '0;
        end else begin
            case (phase_q)
                IDLE: begin
                    phase_d = ALIVE;
                    dmg_d   = '0;
                    timer_d = '0;
                end
                ALIVE: begin
                    if (dmg_sum != '0) begin
                        if (dmg_acc >= AW'(LIFE_MAX)) begin
                            dmg_d      = DW'(LIFE_MAX);
                            phase_d    = DEAD;
                            dead_entry = 1'b1;
                        end else begin
                            dmg_d = dmg_acc[DW-1:0];
                            if (INVULN_CYC > 0) begin
                                phase_d = GUARD;
                                timer_d = GUARD_LOAD;
                            end
                        end
                    end
`ifdef PLAYER_STATS_REGEN_EN
                    // Quiet cycles only count while there is damage to heal.
                    else if (dmg_q != '0) begin
                        if (regen_q == RW'(REGEN_PERIOD - 1)) begin
                            dmg_d = dmg_q - DW'(1);
                        end else begin
                            regen_d = regen_q + RW'(1);
                        end
                    end
`endif
                end
                GUARD: begin
                    if (timer_q == '0) begin
                        phase_d = ALIVE;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    phase_d = DEAD;
                end
            endcase
        end

        life_d = (phase_d == IDLE) ? '0 : (FULL_BAR >> dmg_d);
    end

    // Ticket first, then either the death penalty or the hit reward.
    always_comb begin
        money_acc = MW'(money_q);
        if (ticket_i) begin
            money_acc = (money_acc >= MW'(TICKET_COST)) ? money_acc - MW'(TICKET_COST) : '0;
        end
        if (dead_entry) begin
            money_acc = (money_acc >= MW'(DEATH_PENALTY)) ? money_acc - MW'(DEATH_PENALTY) : '0;
        end else if (play && (phase_q == ALIVE || phase_q == GUARD)) begin
            money_acc = money_acc + MW'(hit_cnt);
            if (money_acc > MW'(MONEY_MAX)) money_acc = MW'(MONEY_MAX);
        end
        money_d = money_acc[MONEY_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= IDLE;
            dmg_q        <= '0;
            timer_q      <= '0;
            money_q      <= MONEY_W'(MONEY_INIT);
            life_q       <= '0;
            fail_q       <= 1'b0;
            dead_pulse_q <= 1'b0;
`ifdef PLAYER_STATS_REGEN_EN
            regen_q      <= '0;
`endif
        end else begin
            phase_q      <= phase_d;
            dmg_q        <= dmg_d;
            timer_q      <= timer_d;
            money_q      <= money_d;
            life_q       <= life_d;
            fail_q       <= (phase_d == DEAD);
            dead_pulse_q <= dead_entry;
`ifdef PLAYER_STATS_REGEN_EN
            regen_q      <= regen_d;
`endif
        end
    end

    assign life_o       = life_q;
    assign dmg_o        = dmg_q;
    assign money_o      = money_q;
    assign phase_o      = phase_q;
    assign fail_o       = fail_q;
    assign dead_pulse_o = dead_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_player_stats.sv
// ============================================================================
//  Module   : tb_player_stats
//  Function : Table-driven self-checking bench for player_stats (default
//             parameters), with hand sequences for reset and death corners.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_player_stats;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] state;
    logic [1:0] damage;
    logic [1:0] hit;
    logic       ticket;
    logic [9:0] life;
    logic [3:0] dmg;
    logic [6:0] money;
    logic [1:0] phase;
    logic       fail;
    logic       dead_pulse;

    player_stats dut (
        .clk          (clk),
        .rst          (rst),
        .state_i      (state),
        .damage_i     (damage),
        .hit_i        (hit),
        .ticket_i     (ticket),
        .life_o       (life),
        .dmg_o        (dmg),
        .money_o      (money),
        .phase_o      (phase),
        .fail_o       (fail),
        .dead_pulse_o (dead_pulse)
    );

    always #5 clk = ~clk;

`ifdef PLAYER_STATS_REGEN_EN
    localparam logic [3:0] R1_DMG  = 4'd1;
    localparam logic [9:0] R1_LIFE = 10'h1FF;
    localparam logic [3:0] R2_DMG  = 4'd0;
    localparam logic [9:0] R2_LIFE = 10'h3FF;
`else
    localparam logic [3:0] R1_DMG  = 4'd2;
    localparam logic [9:0] R1_LIFE = 10'h0FF;
    localparam logic [3:0] R2_DMG  = 4'd2;
    localparam logic [9:0] R2_LIFE = 10'h0FF;
`endif

    typedef struct {
        int         n;
        logic [3:0] st;
        logic [1:0] dm;
        logic [1:0] ht;
        logic       tk;
        logic [9:0] e_life;
        logic [3:0] e_dmg;
        logic [6:0] e_money;
        logic [1:0] e_phase;
        logic       e_fail;
        logic       e_dp;
    } vec_t;

    localparam int NV = 44;
    vec_t tbl [NV];

    int n_pass  = 0;
    int n_total = 0;

    function automatic vec_t mk(int n, logic [3:0] st, logic [1:0] dm, logic [1:0] ht, logic tk,
                                logic [9:0] l, logic [3:0] d, logic [6:0] m, logic [1:0] ph,
                                logic f, logic dp);
        vec_t v;
        v.n = n; v.st = st; v.dm = dm; v.ht = ht; v.tk = tk;
        v.e_life = l; v.e_dmg = d; v.e_money = m; v.e_phase = ph; v.e_fail = f; v.e_dp = dp;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(input int idx, input logic [9:0] l, input logic [3:0] d, input logic [6:0] m,
                             input logic [1:0] ph, input logic f, input logic dp);
        check("life",       idx, 32'(life),       32'(l));
        check("dmg",        idx, 32'(dmg),        32'(d));
        check("money",      idx, 32'(money),      32'(m));
        check("phase",      idx, 32'(phase),      32'(ph));
        check("fail",       idx, 32'(fail),       32'(f));
        check("dead_pulse", idx, 32'(dead_pulse), 32'(dp));
    endtask

    task automatic drive(input logic [3:0] s, input logic [1:0] d, input logic [1:0] h, input logic t);
        state  = s;
        damage = d;
        hit    = h;
        ticket = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           n   st    dm     ht     tk    life    dmg  money ph  f  dp
        tbl[0]  = mk(1,  4'd1, 2'b00, 2'b00, 1'b0, 10'h3FF, 4'd0,  7'd20, 2'd1, 1'b0, 1'b0);
        tbl[1]  = mk(1,  4'd1, 2'b11, 2'b00, 1'b0, 10'h07F, 4'd3,  7'd20, 2'd2, 1'b0, 1'b0);
        tbl[2]  = mk(7,  4'd1, 2'b11, 2'b00, 1'b0, 10'h07F, 4'd3,  7'd20, 2'd2, 1'b0, 1'b0);
        tbl[3]  = mk(1,  4'd1, 2'b11, 2'b00, 1'b0, 10'h07F, 4'd3,  7'd20, 2'd1, 1'b0, 1'b0);
        tbl[4]  = mk(1,  4'd1, 2'b01, 2'b00, 1'b0, 10'h03F, 4'd4,  7'd20, 2'd2, 1'b0, 1'b0);
        tbl[5]  = mk(8,  4'd1, 2'b00, 2'b11, 1'b0, 10'h03F, 4'd4,  7'd36, 2'd1, 1'b0, 1'b0);
        tbl[6]  = mk(1,  4'd1, 2'b11, 2'b01, 1'b0, 10'h007, 4'd7,  7'd37, 2'd2, 1'b0, 1'b0);
        tbl[7]  = mk(8,  4'd1, 2'b00, 2'b00, 1'b0, 10'h007, 4'd7,  7'd37, 2'd1, 1'b0, 1'b0);
        tbl[8]  = mk(1,  4'd1, 2'b01, 2'b00, 1'b0, 10'h003, 4'd8,  7'd37, 2'd2, 1'b0, 1'b0);
        tbl[9]  = mk(8,  4'd1, 2'b00, 2'b00, 1'b0, 10'h003, 4'd8,  7'd37, 2'd1, 1'b0, 1'b0);
        tbl[10] = mk(1,  4'd1, 2'b10, 2'b11, 1'b0, 10'h000, 4'd10, 7'd32, 2'd3, 1'b1, 1'b1);
        tbl[11] = mk(3,  4'd1, 2'b11, 2'b11, 1'b0, 10'h000, 4'd10, 7'd32, 2'd3, 1'b1, 1'b0);
        tbl[12] = mk(1,  4'd1, 2'b00, 2'b00, 1'b1, 10'h000, 4'd10, 7'd22, 2'd3, 1'b1, 1'b0);
        tbl[13] = mk(1,  4'd0, 2'b00, 2'b00, 1'b0, 10'h000, 4'd0,  7'd22, 2'd0, 1'b0, 1'b0);
        tbl[14] = mk(1,  4'd2, 2'b00, 2'b00, 1'b0, 10'h3FF, 4'd0,  7'd22, 2'd1, 1'b0, 1'b0);
        tbl[15] = mk(1,  4'd7, 2'b11, 2'b11, 1'b0, 10'h000, 4'd0,  7'd22, 2'd0, 1'b0, 1'b0);
        tbl[16] = mk(1,  4'd4, 2'b00, 2'b00, 1'b0, 10'h3FF, 4'd0,  7'd22, 2'd1, 1'b0, 1'b0);
        tbl[17] = mk(1,  4'd4, 2'b11, 2'b00, 1'b0, 10'h07F, 4'd3,  7'd22, 2'd2, 1'b0, 1'b0);
        tbl[18] = mk(8,  4'd4, 2'b00, 2'b00, 1'b0, 10'h07F, 4'd3,  7'd22, 2'd1, 1'b0, 1'b0);
        tbl[19] = mk(1,  4'd4, 2'b11, 2'b00, 1'b0, 10'h00F, 4'd6,  7'd22, 2'd2, 1'b0, 1'b0);
        tbl[20] = mk(8,  4'd4, 2'b00, 2'b00, 1'b0, 10'h00F, 4'd6,  7'd22, 2'd1, 1'b0, 1'b0);
        tbl[21] = mk(1,  4'd4, 2'b11, 2'b00, 1'b0, 10'h001, 4'd9,  7'd22, 2'd2, 1'b0, 1'b0);
        tbl[22] = mk(8,  4'd4, 2'b00, 2'b00, 1'b0, 10'h001, 4'd9,  7'd22, 2'd1, 1'b0, 1'b0);
        tbl[23] = mk(1,  4'd4, 2'b11, 2'b00, 1'b0, 10'h000, 4'd10, 7'd17, 2'd3, 1'b1, 1'b1);
        tbl[24] = mk(1,  4'd0, 2'b00, 2'b00, 1'b0, 10'h000, 4'd0,  7'd17, 2'd0, 1'b0, 1'b0);
        tbl[25] = mk(1,  4'd1, 2'b00, 2'b00, 1'b0, 10'h3FF, 4'd0,  7'd17, 2'd1, 1'b0, 1'b0);
        tbl[26] = mk(40, 4'd1, 2'b00, 2'b11, 1'b0, 10'h3FF, 4'd0,  7'd97, 2'd1, 1'b0, 1'b0);
        tbl[27] = mk(1,  4'd1, 2'b00, 2'b01, 1'b0, 10'h3FF, 4'd0,  7'd98, 2'd1, 1'b0, 1'b0);
        tbl[28] = mk(1,  4'd1, 2'b00, 2'b11, 1'b0, 10'h3FF, 4'd0,  7'd99, 2'd1, 1'b0, 1'b0);
        tbl[29] = mk(1,  4'd1, 2'b00, 2'b11, 1'b0, 10'h3FF, 4'd0,  7'd99, 2'd1, 1'b0, 1'b0);
        tbl[30] = mk(1,  4'd1, 2'b00, 2'b00, 1'b1, 10'h3FF, 4'd0,  7'd89, 2'd1, 1'b0, 1'b0);
        tbl[31] = mk(8,  4'd1, 2'b00, 2'b00, 1'b1, 10'h3FF, 4'd0,  7'd9,  2'd1, 1'b0, 1'b0);
        tbl[32] = mk(2,  4'd1, 2'b00, 2'b11, 1'b0, 10'h3FF, 4'd0,  7'd13, 2'd1, 1'b0, 1'b0);
        tbl[33] = mk(1,  4'd1, 2'b00, 2'b01, 1'b0, 10'h3FF, 4'd0,  7'd14, 2'd1, 1'b0, 1'b0);
        tbl[34] = mk(1,  4'd1, 2'b00, 2'b00, 1'b1, 10'h3FF, 4'd0,  7'd4,  2'd1, 1'b0, 1'b0);
        tbl[35] = mk(1,  4'd1, 2'b00, 2'b00, 1'b1, 10'h3FF, 4'd0,  7'd0,  2'd1, 1'b0, 1'b0);
        tbl[36] = mk(1,  4'd1, 2'b00, 2'b11, 1'b1, 10'h3FF, 4'd0,  7'd2,  2'd1, 1'b0, 1'b0);
        tbl[37] = mk(1,  4'd0, 2'b00, 2'b00, 1'b1, 10'h000, 4'd0,  7'd0,  2'd0, 1'b0, 1'b0);
        tbl[38] = mk(1,  4'd1, 2'b00, 2'b00, 1'b0, 10'h3FF, 4'd0,  7'd0,  2'd1, 1'b0, 1'b0);
        tbl[39] = mk(1,  4'd1, 2'b10, 2'b00, 1'b0, 10'h0FF, 4'd2,  7'd0,  2'd2, 1'b0, 1'b0);
        tbl[40] = mk(8,  4'd1, 2'b00, 2'b00, 1'b0, 10'h0FF, 4'd2,  7'd0,  2'd1, 1'b0, 1'b0);
        tbl[41] = mk(63, 4'd1, 2'b00, 2'b00, 1'b0, 10'h0FF, 4'd2,  7'd0,  2'd1, 1'b0, 1'b0);
        tbl[42] = mk(1,  4'd1, 2'b00, 2'b00, 1'b0, R1_LIFE, R1_DMG, 7'd0, 2'd1, 1'b0, 1'b0);
        tbl[43] = mk(64, 4'd1, 2'b00, 2'b00, 1'b0, R2_LIFE, R2_DMG, 7'd0, 2'd1, 1'b0, 1'b0);

        rst = 1'b1;
        drive(4'd1, 2'b11, 2'b11, 1'b1);
        tick();
        tick();
        check_all(100, 10'h000, 4'd0, 7'd20, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].st, tbl[i].dm, tbl[i].ht, tbl[i].tk);
            repeat (tbl[i].n) tick();
            check_all(i, tbl[i].e_life, tbl[i].e_dmg, tbl[i].e_money,
                      tbl[i].e_phase, tbl[i].e_fail, tbl[i].e_dp);
        end

        // Reset in the middle of an invulnerability window.
        drive(4'd1, 2'b11, 2'b00, 1'b0);
        tick();
        check("guard_entry", 200, 32'(phase), 32'd2);
        rst = 1'b1;
        tick();
        check_all(201, 10'h000, 4'd0, 7'd20, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(4'd1, 2'b00, 2'b00, 1'b0);
        tick();
        check_all(202, 10'h3FF, 4'd0, 7'd20, 2'd1, 1'b0, 1'b0);

        // Walk to death, then confirm the pulse does not repeat and DEAD is sticky.
        for (int k = 0; k < 3; k++) begin
            drive(4'd1, 2'b11, 2'b00, 1'b0);
            tick();
            drive(4'd1, 2'b00, 2'b00, 1'b0);
            repeat (8) tick();
        end
        check_all(203, 10'h001, 4'd9, 7'd20, 2'd1, 1'b0, 1'b0);
        drive(4'd1, 2'b11, 2'b11, 1'b0);
        tick();
        check_all(204, 10'h000, 4'd10, 7'd15, 2'd3, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all(205 + k, 10'h000, 4'd10, 7'd15, 2'd3, 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        check_all(210, 10'h000, 4'd0, 7'd20, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
